// File: rtl/turn_signal_controller_pkg.sv
// Shared turn-indicator definitions: FSM encoding and 50 MHz timing defaults,
// so the dashboard and sound blocks agree on identical values.
package turn_signal_controller_pkg;

  localparam int unsigned BLINK_HALF_CYCLES_DEF = 16_666_667;  // 1.5 Hz at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 500_000;     // 10 ms
  localparam int unsigned TAP_CYCLES_DEF        = 25_000_000;  // 0.5 s
  localparam int unsigned COMFORT_FLASHES_DEF   = 3;
  localparam logic [2:0]  FLASH_SAT             = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_HAZARD,
    ST_COMFORT
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/turn_signal_controller_switch_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the output level
// follows the input only after it has differed for DEBOUNCE_CYCLES clocks.
module switch_debouncer
  import turn_signal_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_level = level_q;

endmodule

// File: rtl/turn_signal_controller.sv
// Turn-indicator controller: debounced switches drive a LEFT/RIGHT/HAZARD/COMFORT
// FSM and a shared blink engine; lamp and phase outputs are registered.
module turn_signal_controller
  import turn_signal_controller_pkg::*;
#(
  parameter int unsigned BLINK_HALF_CYCLES = BLINK_HALF_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TAP_CYCLES        = TAP_CYCLES_DEF,
  parameter int unsigned COMFORT_FLASHES   = COMFORT_FLASHES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic engine_on,
  input  logic left_sw,
  input  logic right_sw,
  input  logic hazard_sw,
  output logic turn_signal_on,
  output logic left_lamp,
  output logic right_lamp,
  output logic hazard_active
);

  localparam int unsigned TW = $clog2(max_u(BLINK_HALF_CYCLES, TAP_CYCLES) + 1);

  logic l_deb, r_deb, h_deb;

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .sw_raw(left_sw), .sw_level(l_deb));
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .sw_raw(right_sw), .sw_level(r_deb));
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hazard (
    .clk(clk), .rst_n(rst_n), .sw_raw(hazard_sw), .sw_level(h_deb));

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] half_q, half_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [2:0]    flash_q, flash_d;
  logic          turn_q, turn_d, left_q, left_d, right_q, right_d, haz_q, haz_d;

  logic l_only, r_only, half_end, entry, in_dir_d;

  // Both direction switches together count as neither.
  assign l_only   = l_deb & ~r_deb;
  assign r_only   = r_deb & ~l_deb;
  assign half_end = (half_q == TW'(BLINK_HALF_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (h_deb) begin
      state_d = ST_HAZARD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (engine_on && l_only)      state_d = ST_LEFT;
          else if (engine_on && r_only) state_d = ST_RIGHT;
        end
        ST_LEFT, ST_RIGHT: begin
          if (!engine_on) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_LEFT && r_only) begin
            state_d = ST_RIGHT;
          end else if (state_q == ST_RIGHT && l_only) begin
            state_d = ST_LEFT;
          end else if (!(state_q == ST_LEFT ? l_only : r_only)) begin
            if (tap_q < TW'(TAP_CYCLES)) begin
              state_d = ST_COMFORT;
              dir_d   = (state_q == ST_LEFT) ? DIR_LEFT : DIR_RIGHT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_COMFORT: begin
          if (!engine_on)   state_d = ST_IDLE;
          else if (l_only)  state_d = ST_LEFT;
          else if (r_only)  state_d = ST_RIGHT;
          else if (phase_q && half_end && (32'(flash_q) >= COMFORT_FLASHES))
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // COMFORT inherits the running phase and flash count; other changes restart.
  assign entry    = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_COMFORT);
  assign in_dir_d = (state_d == ST_LEFT) || (state_d == ST_RIGHT);

  always_comb begin
    phase_d = phase_q;
    half_d  = half_q;
    flash_d = flash_q;
    tap_d   = tap_q;
    if (state_d == ST_IDLE) begin
      phase_d = 1'b0;
      half_d  = '0;
      flash_d = '0;
      tap_d   = '0;
    end else if (entry) begin
      phase_d = 1'b1;
      half_d  = '0;
      flash_d = 3'd1;
      tap_d   = '0;
    end else begin
      if (half_end) begin
        half_d  = '0;
        phase_d = ~phase_q;
        if (!phase_q && flash_q != FLASH_SAT) flash_d = flash_q + 3'd1;
      end else begin
        half_d = half_q + 1'b1;
      end
      if (!in_dir_d)                        tap_d = '0;
      else if (tap_q != TW'(TAP_CYCLES))    tap_d = tap_q + 1'b1;
    end
  end

  always_comb begin
    turn_d  = phase_q && (state_q != ST_IDLE);
    left_d  = phase_q && ((state_q == ST_LEFT) || (state_q == ST_HAZARD) ||
                          (state_q == ST_COMFORT && dir_q == DIR_LEFT));
    right_d = phase_q && ((state_q == ST_RIGHT) || (state_q == ST_HAZARD) ||
                          (state_q == ST_COMFORT && dir_q == DIR_RIGHT));
    haz_d   = (state_q == ST_HAZARD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_LEFT;
      phase_q <= 1'b0;
      half_q  <= '0;
      tap_q   <= '0;
      flash_q <= '0;
      turn_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      haz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      tap_q   <= tap_d;
      flash_q <= flash_d;
      turn_q  <= turn_d;
      left_q  <= left_d;
      right_q <= right_d;
      haz_q   <= haz_d;
    end
  end

  assign turn_signal_on = turn_q;
  assign left_lamp      = left_q;
  assign right_lamp     = right_q;
  assign hazard_active  = haz_q;

endmodule

// File: tb/tb_turn_signal_controller.sv
// Directed bench for turn_signal_controller with short timing parameters;
// expected values are hand-derived cycle counts from the raw switch edge.
module tb_turn_signal_controller;

  localparam int unsigned BH = 10;
  localparam int unsigned DB = 4;
  localparam int unsigned TP = 25;
  localparam int unsigned CF = 3;

  logic clk = 1'b0;
  logic rst_n, engine_on, left_sw, right_sw, hazard_sw;
  logic turn_signal_on, left_lamp, right_lamp, hazard_active;

  int n_checks = 0;
  int n_fail   = 0;
  int left_rises  = 0;
  int right_rises = 0;
  logic left_prev  = 1'b0;
  logic right_prev = 1'b0;
  int snap_l, snap_r;

  turn_signal_controller #(
    .BLINK_HALF_CYCLES(BH),
    .DEBOUNCE_CYCLES  (DB),
    .TAP_CYCLES       (TP),
    .COMFORT_FLASHES  (CF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .engine_on     (engine_on),
    .left_sw       (left_sw),
    .right_sw      (right_sw),
    .hazard_sw     (hazard_sw),
    .turn_signal_on(turn_signal_on),
    .left_lamp     (left_lamp),
    .right_lamp    (right_lamp),
    .hazard_active (hazard_active)
  );

  always #5 clk = ~clk;

  // Cumulative count of lamp ON phases (rising edges), sampled mid-cycle.
  always @(negedge clk) begin
    if (left_lamp && !left_prev)   left_rises  <= left_rises + 1;
    if (right_lamp && !right_prev) right_rises <= right_rises + 1;
    left_prev  <= left_lamp;
    right_prev <= right_lamp;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic l, input logic r,
                            input logic t, input logic h);
    check({tag, ".left"},   32'(left_lamp),      32'(l));
    check({tag, ".right"},  32'(right_lamp),     32'(r));
    check({tag, ".turn"},   32'(turn_signal_on), 32'(t));
    check({tag, ".hazard"}, 32'(hazard_active),  32'(h));
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; engine_on = 1'b0;
    left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check_outs("post_reset", 0, 0, 0, 0);

    // 1. Hazard with engine off: lamps on exactly 2+DB+2 = 8 clocks after the press.
    hazard_sw = 1'b1;
    tick(7);  check_outs("haz_edge7", 0, 0, 0, 0);
    tick(1);  check_outs("haz_edge8", 1, 1, 1, 1);
    tick(9);  check("haz_on_last", 32'(turn_signal_on), 1);
    tick(1);  check("haz_off_first", 32'(turn_signal_on), 0);
    check("haz_active_off_phase", 32'(hazard_active), 1);
    tick(10); check("haz_on_again", 32'(turn_signal_on), 1);
    hazard_sw = 1'b0;
    tick(8);  check_outs("haz_release", 0, 0, 0, 0);

    // 2. Left held 100 clocks: five ON phases, no comfort afterwards.
    engine_on = 1'b1;
    tick(5);
    snap_l = left_rises; snap_r = right_rises;
    left_sw = 1'b1;
    tick(8);  check_outs("left_start", 1, 0, 1, 0);
    tick(92);
    left_sw = 1'b0;
    tick(50);
    check("left_hold_flashes", 32'(left_rises - snap_l), 5);
    check("left_hold_right", 32'(right_rises - snap_r), 0);
    check_outs("left_hold_idle", 0, 0, 0, 0);

    // 3. Left tap of 15 clocks: comfort blink of exactly three ON phases.
    snap_l = left_rises;
    left_sw = 1'b1;
    tick(15);
    left_sw = 1'b0;
    tick(42); check("tap_third_on_last", 32'(left_lamp), 1);
    tick(1);  check("tap_third_on_end", 32'(left_lamp), 0);
    tick(60);
    check("tap_flashes", 32'(left_rises - snap_l), CF);
    check_outs("tap_idle", 0, 0, 0, 0);

    // 4. Both directions together are ignored; a 3-clock glitch is filtered.
    snap_l = left_rises; snap_r = right_rises;
    left_sw = 1'b1; right_sw = 1'b1;
    tick(40);
    check_outs("both_sw", 0, 0, 0, 0);
    left_sw = 1'b0; right_sw = 1'b0;
    tick(20);
    right_sw = 1'b1;
    tick(3);
    right_sw = 1'b0;
    tick(30);
    check("glitch_right", 32'(right_rises - snap_r), 0);
    check("both_left", 32'(left_rises - snap_l), 0);

    // 5a. RIGHT active, engine turned off: outputs drop within two clocks.
    right_sw = 1'b1;
    tick(12); check_outs("right_on", 0, 1, 1, 0);
    engine_on = 1'b0;
    tick(2);  check_outs("engine_off", 0, 0, 0, 0);
    right_sw = 1'b0;
    tick(10);
    engine_on = 1'b1;
    tick(5);

    // 5b. LEFT active, hazard pressed during LEFT's OFF phase: phase restarts ON.
    left_sw = 1'b1;
    tick(13); check("left_before_haz", 32'(left_lamp), 1);
    hazard_sw = 1'b1;
    tick(7);  check_outs("haz_pending", 0, 0, 0, 0);
    tick(1);  check_outs("haz_from_left", 1, 1, 1, 1);
    tick(9);  check_outs("haz_from_left_last", 1, 1, 1, 1);
    tick(1);  check_outs("haz_from_left_off", 0, 0, 0, 1);
    left_sw = 1'b0; hazard_sw = 1'b0;
    tick(20);
    check_outs("haz_from_left_idle", 0, 0, 0, 0);

    // 6. Reset mid-ON in HAZARD clears outputs at once; debounce reapplies after.
    hazard_sw = 1'b1;
    tick(12); check_outs("haz_pre_reset", 1, 1, 1, 1);
    rst_n = 1'b0;
    #1;       check_outs("async_reset", 0, 0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(7);  check_outs("reset_redebounce", 0, 0, 0, 0);
    tick(1);  check_outs("reset_resume", 1, 1, 1, 1);
    hazard_sw = 1'b0;
    tick(20);
    check_outs("final_idle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_signal_controller.md
Name: turn_signal_controller

Overview:
Generates the turn-indicator blink state for the vehicle. Inputs are the raw left, right and hazard switch levels plus the engine state. Outputs are the left and right lamp drives and the turn_signal_on phase line, which the sound block consumes to produce its tick/tock clicks. A short tap on a direction switch gives a three-flash comfort blink.

Parameters:
BLINK_HALF_CYCLES, 16_666_667, clocks per ON or OFF half-phase (1.5 Hz at 50 MHz)
DEBOUNCE_CYCLES, 500_000, consecutive stable clocks required before a switch level is accepted (10 ms)
TAP_CYCLES, 25_000_000, a direction hold shorter than this is a tap (0.5 s)
COMFORT_FLASHES, 3, number of ON phases produced by a tap

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
engine_on  in  1  engine running; gates left/right, not hazard
left_sw  in  1  raw left switch, asynchronous
right_sw  in  1  raw right switch, asynchronous
hazard_sw  in  1  raw hazard switch, asynchronous
turn_signal_on  out  1  blink phase, 1 = ON; feeds the sound block
left_lamp  out  1  left indicator drive
right_lamp  out  1  right indicator drive
hazard_active  out  1  high while in HAZARD

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n = 0, all outputs, timers, counters and debounced levels are 0 and the state is IDLE, effective immediately.
- Switch conditioning, per switch:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks.
  - Any bounce restarts the count.
- The FSM acts on debounced levels L, R, H.
- States: IDLE, LEFT, RIGHT, HAZARD, COMFORT (COMFORT holds a dir bit).
- Priority:
  - H = 1 → HAZARD from any state, regardless of engine_on.
  - Otherwise L and R both 1 → treated as neither.
- IDLE:
  - L & ~R & engine_on → LEFT.
  - R & ~L & engine_on → RIGHT.
- LEFT/RIGHT:
  - A tap timer runs from entry.
  - On release with tap timer < TAP_CYCLES → COMFORT (same direction); the flash count carries over.
  - On release at or after TAP_CYCLES → IDLE.
  - Opposite switch alone → the other direction state; phase restarts, flash count cleared.
- COMFORT:
  - At the end of an ON phase, if flash count >= COMFORT_FLASHES → IDLE.
  - A new L or R press → LEFT/RIGHT; phase restarts, count cleared.
- HAZARD:
  - H released → IDLE, not a resumed direction.
  - Both lamps blink together.
- engine_on = 0 in LEFT/RIGHT/COMFORT → IDLE on the next clock.
- Blink engine:
  - On entry to any active state: phase = ON on the next clock, half-phase timer = 0, flash count = 1.
  - The phase toggles every BLINK_HALF_CYCLES clocks.
  - Each OFF→ON transition increments the flash count, saturating at 7.
- Outputs are registered:
  - turn_signal_on = phase in active states.
  - left_lamp = phase in LEFT, in COMFORT with dir = left, and in HAZARD.
  - right_lamp is the mirror.
  - Entering IDLE forces all outputs to 0 on the next clock, so a falling click may occur; this is intended.
- Latency, raw switch edge to first lamp ON: 2 (sync) + DEBOUNCE_CYCLES + 2 clocks.
- Timer width is $clog2 of the largest cycle parameter; timers never wrap because they are cleared at terminal count.

Decomposition:
- Shared package: FSM state encoding and the 50 MHz default timing constants, so the dashboard and sound blocks use identical values.
- One sub-module: switch_debouncer (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
Simulation parameters for all scenarios: BLINK_HALF_CYCLES = 10, DEBOUNCE_CYCLES = 4, TAP_CYCLES = 25, COMFORT_FLASHES = 3.
1. hazard_sw = 1 with engine_on = 0 → hazard_active and both lamps ON 8 clocks later; turn_signal_on toggles every 10 clocks; release → all 0 within 8 clocks.
2. engine_on = 1, left_sw held 100 clocks → left_lamp toggles with 5 ON phases, right_lamp stays 0; release → IDLE, outputs 0.
3. left_sw held 15 clocks → exactly 3 ON phases of 10 clocks on left_lamp, then all outputs 0 and no further toggling.
4. left_sw and right_sw rise together → no lamp activity; a 3-clock glitch on right_sw → ignored.
5. RIGHT active, engine_on → 0 → outputs 0 next clock; LEFT active, hazard pressed → both lamps blink with the phase restarted.
6. rst_n pulsed low mid-ON-phase in HAZARD → all outputs 0 in the same cycle; after release, blinking resumes only after debounce.
